// File: rtl/traffic_pkg.sv
// Shared encodings for the A/B traffic-light controller and its congestion counter.
package traffic_pkg;

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    A_STATE     = 3'd1,
    B_STATE     = 3'd2,
    A_IS_GREEN  = 3'd3,
    B_IS_GREEN  = 3'd4,
    BLINK_STATE = 3'd5,
    A_YELLOW    = 3'd6,
    B_YELLOW    = 3'd7
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam int unsigned TIMER_W = 10;

  // Terminal timer value for a phase lasting n cycles.
  function automatic logic [TIMER_W-1:0] last_cyc(input int unsigned n);
    return TIMER_W'(n - 1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 10-bit phase counter: synchronous clear, enable, saturates at limit, flags done.
module phase_timer
  import traffic_pkg::*;
(
  input  logic               CLK,
  input  logic               Reset,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] limit,
  output logic [TIMER_W-1:0] t,
  output logic               done
);

  always_ff @(posedge CLK) begin
    if (Reset)
      t <= '0;
    else if (clr)
      t <= '0;
    else if (en && (t < limit))
      t <= t + TIMER_W'(1);
  end

  assign done = (t >= limit);

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road traffic-light controller: green/monitor/yellow sequencing with
// congestion or max-time handover and a maintenance blink mode.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned STOP_LIMIT  = 8,
  parameter int unsigned MIN_GREEN   = 16,
  parameter int unsigned MAX_GREEN   = 64,
  parameter int unsigned YELLOW_CYC  = 4,
  parameter int unsigned ALL_RED_CYC = 2,
  parameter int unsigned BLINK_HALF  = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       A_Traffic,
  input  logic       B_Traffic,
  input  logic [9:0] Traffic_stop,
  input  logic       Blink_en,
  output logic [2:0] state,
  output logic [2:0] A_light,
  output logic [2:0] B_light
);

  state_t               cur_state, nxt_state;
  logic                 blink_phase;
  logic                 t_clr, t_done, congested;
  logic [TIMER_W-1:0]   t_limit, t;

  phase_timer u_timer (
    .CLK   (CLK),
    .Reset (Reset),
    .clr   (t_clr),
    .en    (1'b1),
    .limit (t_limit),
    .t     (t),
    .done  (t_done)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cur_state   <= INIT;
      blink_phase <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state != BLINK_STATE)
        blink_phase <= 1'b0;
      else if (t_done)
        blink_phase <= ~blink_phase;
    end
  end

  assign congested = (Traffic_stop >= 10'(STOP_LIMIT));

  always_comb begin
    t_limit = last_cyc(ALL_RED_CYC);
    case (cur_state)
      A_IS_GREEN, B_IS_GREEN: t_limit = last_cyc(MIN_GREEN);
      A_STATE, B_STATE:       t_limit = last_cyc(MAX_GREEN);
      A_YELLOW, B_YELLOW:     t_limit = last_cyc(YELLOW_CYC);
      BLINK_STATE:            t_limit = last_cyc(BLINK_HALF);
      default:                t_limit = last_cyc(ALL_RED_CYC);
    endcase
  end

  always_comb begin
    nxt_state = cur_state;
    if (Blink_en && (cur_state != BLINK_STATE)) begin
      nxt_state = BLINK_STATE;
    end else begin
      case (cur_state)
        INIT:        if (t_done) nxt_state = A_IS_GREEN;
        A_IS_GREEN:  if (t_done) nxt_state = B_STATE;
        B_STATE:     if (congested || (t_done && B_Traffic)) nxt_state = A_YELLOW;
        A_YELLOW:    if (t_done) nxt_state = B_IS_GREEN;
        B_IS_GREEN:  if (t_done) nxt_state = A_STATE;
        A_STATE:     if (congested || (t_done && A_Traffic)) nxt_state = B_YELLOW;
        B_YELLOW:    if (t_done) nxt_state = A_IS_GREEN;
        BLINK_STATE: if (!Blink_en) nxt_state = INIT;
        default:     nxt_state = INIT;
      endcase
    end
  end

  // Timer restarts on every state change and on each blink half-period.
  assign t_clr = (nxt_state != cur_state) || ((cur_state == BLINK_STATE) && t_done);

  always_comb begin
    A_light = RED;
    B_light = RED;
    case (cur_state)
      A_IS_GREEN, B_STATE: A_light = GRN;
      A_YELLOW:            A_light = YEL;
      B_IS_GREEN, A_STATE: B_light = GRN;
      B_YELLOW:            B_light = YEL;
      BLINK_STATE: begin
        A_light = {1'b0, blink_phase, 1'b0};
        B_light = {1'b0, blink_phase, 1'b0};
      end
      default: ;
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed and random-stimulus bench for traffic_light_fsm with a safety monitor.
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       A_Traffic, B_Traffic, Blink_en;
  logic [9:0] Traffic_stop;
  logic [2:0] state, A_light, B_light;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        mon_en   = 1'b0;

  traffic_light_fsm #(
    .STOP_LIMIT  (8),
    .MIN_GREEN   (16),
    .MAX_GREEN   (64),
    .YELLOW_CYC  (4),
    .ALL_RED_CYC (2),
    .BLINK_HALF  (8)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .A_Traffic    (A_Traffic),
    .B_Traffic    (B_Traffic),
    .Traffic_stop (Traffic_stop),
    .Blink_en     (Blink_en),
    .state        (state),
    .A_light      (A_light),
    .B_light      (B_light)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string tag, input state_t st, input logic [2:0] a, input logic [2:0] b);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".A"}, 32'(A_light), 32'(a));
    check({tag, ".B"}, 32'(B_light), 32'(b));
  endtask

  // Safety: never two non-red lights outside blink; state always a known code.
  always @(negedge CLK) begin
    if (mon_en && !Reset) begin
      check("safe", 32'(!((state != 3'd5) && (A_light != RED) && (B_light != RED))), 32'd1);
      check("valid", 32'(!$isunknown(state)), 32'd1);
    end
  end

  initial begin
    Reset = 1'b1; A_Traffic = 1'b0; B_Traffic = 1'b0; Blink_en = 1'b0; Traffic_stop = '0;
    repeat (3) step();
    mon_en = 1'b1;
    expect_out("rst", INIT, RED, RED);
    check("rst_t", 32'(dut.u_timer.t), 32'd0);
    Reset = 1'b0;

    // INIT 2 cycles, A green 16 cycles, then B monitoring
    step(); expect_out("init2", INIT, RED, RED);
    repeat (16) begin step(); expect_out("ag1", A_IS_GREEN, GRN, RED); end
    step(); expect_out("bmon1", B_STATE, GRN, RED);

    // One below the congestion limit with no B demand: hold indefinitely
    Traffic_stop = 10'd7;
    repeat (70) begin step(); expect_out("bhold", B_STATE, GRN, RED); end
    B_Traffic = 1'b1;
    step(); expect_out("bmax", A_YELLOW, YEL, RED);
    B_Traffic = 1'b0; Traffic_stop = '0;
    repeat (3) begin step(); expect_out("ay1", A_YELLOW, YEL, RED); end
    repeat (16) begin step(); expect_out("bg1", B_IS_GREEN, RED, GRN); end
    step(); expect_out("amon1", A_STATE, RED, GRN);

    // A demand present throughout: forced handover after exactly 64 cycles
    A_Traffic = 1'b1; Traffic_stop = 10'd3;
    repeat (63) begin step(); expect_out("amax", A_STATE, RED, GRN); end
    step(); expect_out("by1", B_YELLOW, RED, YEL);
    A_Traffic = 1'b0; Traffic_stop = '0;
    repeat (3) begin step(); expect_out("by2", B_YELLOW, RED, YEL); end
    repeat (16) begin step(); expect_out("ag2", A_IS_GREEN, GRN, RED); end
    step(); expect_out("bmon2", B_STATE, GRN, RED);

    // Congestion ramp 0..8: handover on the edge that samples 8
    B_Traffic = 1'b1;
    for (int v = 0; v <= 8; v++) begin
      Traffic_stop = 10'(v);
      step();
      if (v < 8) expect_out("ramp", B_STATE, GRN, RED);
      else       expect_out("cong", A_YELLOW, YEL, RED);
    end
    B_Traffic = 1'b0; Traffic_stop = '0;
    step(); expect_out("ay2", A_YELLOW, YEL, RED);

    // Blink requested mid-yellow
    Blink_en = 1'b1;
    step(); expect_out("blk0", BLINK_STATE, OFF, OFF);
    for (int i = 1; i < 24; i++) begin
      step();
      if (((i / 8) % 2) == 1) expect_out("blkon", BLINK_STATE, YEL, YEL);
      else                    expect_out("blkoff", BLINK_STATE, OFF, OFF);
    end
    Blink_en = 1'b0;
    step(); expect_out("binit1", INIT, RED, RED);
    step(); expect_out("binit2", INIT, RED, RED);
    repeat (16) begin step(); expect_out("ag3", A_IS_GREEN, GRN, RED); end
    step(); expect_out("bmon3", B_STATE, GRN, RED);

    // Reset mid-monitoring
    Traffic_stop = 10'd7;
    repeat (5) begin step(); expect_out("bmon4", B_STATE, GRN, RED); end
    Reset = 1'b1;
    step(); expect_out("rst2", INIT, RED, RED);
    check("rst2_t", 32'(dut.u_timer.t), 32'd0);
    Reset = 1'b0; Traffic_stop = '0;
    step(); expect_out("rinit", INIT, RED, RED);
    step(); expect_out("rag", A_IS_GREEN, GRN, RED);

    // Random stimulus under the safety monitor
    repeat (3000) begin
      A_Traffic    = 1'($urandom_range(0, 1));
      B_Traffic    = 1'($urandom_range(0, 1));
      Traffic_stop = 10'($urandom_range(0, 12));
      if ($urandom_range(0, 99) < 2) Blink_en = ~Blink_en;
      step();
    end
    Blink_en = 1'b0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
